// File: rtl/seven_seg_multi_driver_if.sv
// Load/display bus between register logic and the seven-segment driver.
// The master supplies value and load controls; the slave returns status and segments.
interface seven_seg_multi_driver_if #(
  parameter int NUM_DIGITS = 6
);
  localparam int DATA_W = 4 * NUM_DIGITS;

  logic [DATA_W-1:0]       value_in;
  logic                    load;
  logic                    mode_dec;
  logic                    blank_lz;
  logic                    busy;
  logic                    done;
  logic [7*NUM_DIGITS-1:0] seg_out;

  modport master (
    output value_in, load, mode_dec, blank_lz,
    input  busy, done, seg_out
  );

  modport slave (
    input  value_in, load, mode_dec, blank_lz,
    output busy, done, seg_out
  );
endinterface

// File: rtl/seven_seg_multi_driver.sv
// Multi-digit seven-segment driver: hex or sequential binary-to-BCD decimal display,
// with overflow dashes and optional leading-zero blanking.
//   state | meaning
//   IDLE  | waiting for load; hex loads complete here directly
//   CONV  | shift-add-3 conversion, one value bit per cycle
module seven_seg_multi_driver #(
  parameter int NUM_DIGITS = 6,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic                     clk_ref,
  input logic                     reset,
  seven_seg_multi_driver_if.slave bus
);
  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int BCD_W  = 8 * NUM_DIGITS;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [6:0] ZERO_PAT = ACTIVE_LOW ? 7'h40 : 7'h3F;

  typedef enum logic [0:0] {IDLE, CONV} state_t;

  state_t                  state;
  logic                    busy;
  logic                    done;
  logic                    upd;
  logic [DATA_W-1:0]       digits;
  logic                    blank_f;
  logic                    blank_pend;
  logic                    ovf;
  logic [BCD_W-1:0]        bcd;
  logic [DATA_W-1:0]       shreg;
  logic [CNT_W-1:0]        cnt;
  logic [7*NUM_DIGITS-1:0] seg_r;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_next;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    zero_above;
  logic [3:0]              nib;
  logic [6:0]              gl;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 2 * NUM_DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
  end

  // Walk from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    seg_next   = '0;
    zero_above = 1'b1;
    nib        = '0;
    gl         = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = digits[4*k +: 4];
      if (ovf)
        gl = 7'h3F;
      else if (blank_f && (k != 0) && zero_above && (nib == 4'd0))
        gl = 7'h7F;
      else
        gl = glyph(nib);
      zero_above = zero_above && (nib == 4'd0);
      seg_next[7*k +: 7] = ACTIVE_LOW ? gl : ~gl;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      upd        <= 1'b0;
      digits     <= '0;
      blank_f    <= 1'b0;
      blank_pend <= 1'b0;
      ovf        <= 1'b0;
      bcd        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      seg_r      <= {NUM_DIGITS{ZERO_PAT}};
    end else begin
      upd  <= 1'b0;
      done <= upd;
      if (upd) seg_r <= seg_next;
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (bus.mode_dec) begin
              shreg      <= bus.value_in;
              bcd        <= '0;
              cnt        <= CNT_W'(DATA_W - 1);
              blank_pend <= bus.blank_lz;
              busy       <= 1'b1;
              state      <= CONV;
            end else begin
              digits  <= bus.value_in;
              blank_f <= bus.blank_lz;
              ovf     <= 1'b0;
              upd     <= 1'b1;
            end
          end
        end
        CONV: begin
          bcd   <= bcd_next;
          shreg <= {shreg[DATA_W-2:0], 1'b0};
          if (cnt == '0) begin
            digits  <= bcd_next[DATA_W-1:0];
            ovf     <= |bcd_next[BCD_W-1:DATA_W];
            blank_f <= blank_pend;
            upd     <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.seg_out = seg_r;
endmodule

// File: tb/tb_seven_seg_multi_driver.sv
// Directed and randomized checks of seven_seg_multi_driver against an arithmetic display model,
// running active-low and active-high instances side by side.
module tb_seven_seg_multi_driver;
  localparam int ND = 6;
  localparam int DW = 4 * ND;

  logic clk_ref = 1'b0;
  logic reset;
  always #5 clk_ref = ~clk_ref;

  seven_seg_multi_driver_if #(.NUM_DIGITS(ND)) bus_h ();
  seven_seg_multi_driver_if #(.NUM_DIGITS(ND)) bus_l ();

  assign bus_l.value_in = bus_h.value_in;
  assign bus_l.load     = bus_h.load;
  assign bus_l.mode_dec = bus_h.mode_dec;
  assign bus_l.blank_lz = bus_h.blank_lz;

  seven_seg_multi_driver #(.NUM_DIGITS(ND), .ACTIVE_LOW(1'b1)) dut_h (
    .clk_ref (clk_ref),
    .reset   (reset),
    .bus     (bus_h.slave)
  );

  seven_seg_multi_driver #(.NUM_DIGITS(ND), .ACTIVE_LOW(1'b0)) dut_l (
    .clk_ref (clk_ref),
    .reset   (reset),
    .bus     (bus_l.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] glyph8 [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7*ND-1:0] model_seg(input longint unsigned v, input bit dec,
                                                input bit blz, input bit al);
    int d [ND];
    longint unsigned p = 1;
    bit ovf;
    int msd = 0;
    logic [6:0] g;
    logic [7:0] g8;
    logic [7*ND-1:0] r = '0;
    for (int k = 0; k < ND; k++) begin
      d[k] = dec ? int'((v / p) % 10) : int'((v >> (4 * k)) & 15);
      p = p * 10;
    end
    ovf = dec && (v >= p);
    for (int k = 0; k < ND; k++) if (d[k] != 0) msd = k;
    for (int k = 0; k < ND; k++) begin
      g8 = glyph8[d[k]];
      if (ovf) g = 7'h3F;
      else if (blz && k > msd) g = 7'h7F;
      else g = g8[6:0];
      r[7*k +: 7] = al ? g : ~g;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  // Issues one accepted load and checks busy duration, done pulse and both displays.
  task automatic run_load(input logic [DW-1:0] v, input bit dec, input bit blz);
    int bc;
    bus_h.value_in = v;
    bus_h.mode_dec = dec;
    bus_h.blank_lz = blz;
    bus_h.load     = 1'b1;
    tick();
    bus_h.load = 1'b0;
    if (dec) begin
      bc = 0;
      while (bus_h.busy === 1'b1 && bc < 100) begin
        bc++;
        tick();
      end
      check("busy_cycles", 64'(bc), 64'(DW));
      check("done_early_dec", 64'(bus_h.done), 64'd0);
    end else begin
      check("hex_busy", 64'(bus_h.busy), 64'd0);
      check("done_early_hex", 64'(bus_h.done), 64'd0);
    end
    tick();
    check("done_h", 64'(bus_h.done), 64'd1);
    check("done_l", 64'(bus_l.done), 64'd1);
    check("seg_h", 64'(bus_h.seg_out), 64'(model_seg(64'(v), dec, blz, 1'b1)));
    check("seg_l", 64'(bus_l.seg_out), 64'(model_seg(64'(v), dec, blz, 1'b0)));
    tick();
    check("done_pulse_end", 64'(bus_h.done), 64'd0);
  endtask

  initial begin
    int dones;
    logic [DW-1:0] rv;
    bit rd, rb;

    reset          = 1'b1;
    bus_h.value_in = '0;
    bus_h.load     = 1'b0;
    bus_h.mode_dec = 1'b0;
    bus_h.blank_lz = 1'b0;
    tick();
    tick();
    check("rst_seg_h", 64'(bus_h.seg_out), 64'({ND{7'h40}}));
    check("rst_seg_l", 64'(bus_l.seg_out), 64'({ND{7'h3F}}));
    check("rst_busy", 64'(bus_h.busy), 64'd0);
    check("rst_done", 64'(bus_h.done), 64'd0);
    reset = 1'b0;
    tick();

    run_load(24'h12AB3F, 1'b0, 1'b0);
    check("hex_12ab3f_const", 64'(bus_h.seg_out), 64'({7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}));
    run_load(24'd999999, 1'b1, 1'b0);
    run_load(24'd1000000, 1'b1, 1'b1);
    check("ovf_dash", 64'(bus_h.seg_out), 64'({ND{7'h3F}}));
    run_load(24'h00000A, 1'b0, 1'b1);
    run_load(24'h000000, 1'b0, 1'b1);
    check("zero_blank", 64'(bus_h.seg_out), 64'({{(ND-1){7'h7F}}, 7'h40}));
    run_load(24'd0, 1'b1, 1'b1);
    run_load(24'd4050, 1'b1, 1'b1);
    run_load(24'hFFFFFF, 1'b1, 1'b0);

    // A second load during conversion must be dropped without a done pulse.
    bus_h.value_in = 24'd123;
    bus_h.mode_dec = 1'b1;
    bus_h.blank_lz = 1'b0;
    bus_h.load     = 1'b1;
    tick();
    bus_h.load = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) begin
        bus_h.value_in = 24'h456789;
        bus_h.mode_dec = 1'b0;
        bus_h.load     = 1'b1;
      end else begin
        bus_h.load = 1'b0;
      end
      tick();
      if (bus_h.done === 1'b1) dones++;
    end
    check("dropped_load_dones", 64'(dones), 64'd1);
    check("dropped_load_seg", 64'(bus_h.seg_out), 64'(model_seg(64'd123, 1'b1, 1'b0, 1'b1)));

    // Reset in the middle of a conversion.
    bus_h.value_in = 24'd999999;
    bus_h.mode_dec = 1'b1;
    bus_h.load     = 1'b1;
    tick();
    bus_h.load = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("pre_rst_busy", 64'(bus_h.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(bus_h.busy), 64'd0);
    check("abort_done", 64'(bus_h.done), 64'd0);
    check("abort_seg_h", 64'(bus_h.seg_out), 64'({ND{7'h40}}));
    check("abort_seg_l", 64'(bus_l.seg_out), 64'({ND{7'h3F}}));
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_h.done === 1'b1 || bus_l.done === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    for (int i = 0; i < 12; i++) begin
      rd = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (rd && (i % 3 != 0)) rv = DW'($urandom_range(0, 999999));
      else rv = DW'($urandom);
      if (i % 4 == 1) rv = rv & DW'(32'h000FFF);
      run_load(rv, rd, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_multi_driver.md
# seven_seg_multi_driver

Parametrised multi-digit seven-segment display driver. It latches an unsigned binary value on a load strobe and shows it on NUM_DIGITS digits, in either hexadecimal or decimal. Decimal values are converted sequentially (shift-add-3), and values too large for the display show an overflow indication. Optional leading-zero blanking is supported. It sits between HPS/FPGA register logic and the board HEX pins, replacing one single-digit decoder per digit.

## Interface
- NUM_DIGITS, 6, number of displayed digits (1..8)
- ACTIVE_LOW, 1, 1 = segment on when pin is 0; 0 = outputs inverted
- DATA_W, 4*NUM_DIGITS, input value width (derived, do not override)

- clk_ref  in  1  reference clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- value_in  in  DATA_W  unsigned value sampled on accepted load
- load  in  1  single-cycle request to display value_in
- mode_dec  in  1  sampled with load: 0 = hex, 1 = decimal
- blank_lz  in  1  sampled with load: 1 = blank leading zero digits
- busy  out  1  high while a decimal conversion runs; load ignored while high
- done  out  1  one-cycle pulse when seg_out has been updated for the accepted load
- seg_out  out  7*NUM_DIGITS  segments; digit k at [7k+6:7k], bit order g..a (bit 6 = g); digit 0 is least significant

## Operation
- Glyphs, active-low values: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, b=83, C=C6, d=A1, E=86, F=8E, blank=7F, dash=3F. When ACTIVE_LOW=0, every driven pattern is bitwise inverted.
- Load acceptance: load=1 and busy=0. On acceptance, latch value_in, mode_dec and blank_lz. A load while busy=1 is dropped with no side effect.
- Hex mode: nibble k of the value goes to digit k. No conversion state is entered.
- Decimal mode: FSM states IDLE -> CONV -> IDLE.
  - The internal BCD register holds 2*NUM_DIGITS digits.
  - CONV runs exactly DATA_W iterations, one per cycle. Each iteration adds 3 to every BCD digit that is >=5, then shifts the register left by 1, taking the next value bit MSB-first.
- Overflow (decimal only): if any BCD digit above NUM_DIGITS-1 is nonzero, all digits show dash. Leading-zero blanking is not applied in this case.
- Leading-zero blanking: every digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so a value of 0 shows a single "0".
- The digit register holds the last result until the next accepted load.
- seg_out is a registered encode of the digit register plus the blank and overflow flags.
- Reset clears the FSM to IDLE, busy=0, done=0, digits=0, blank_lz flag=0, and the overflow flag.

## Timing
- Cycle numbering: load accepted at rising edge N.
- Hex mode:
  - Digit register updates at N+1.
  - seg_out and done=1 at N+2.
  - busy stays 0.
- Decimal mode:
  - busy=1 from N+1 through N+DATA_W.
  - Digit register and overflow flag update at N+DATA_W+1; busy=0 in that same cycle.
  - seg_out and done=1 at N+DATA_W+2.
  - The earliest next accepted load is at edge N+DATA_W+1.
- A load asserted in the same cycle that busy falls is accepted.
- Reset outputs: seg_out = all digits showing "0" (7'hC0 each, inverted when ACTIVE_LOW=0), busy=0, done=0.
- Reset has priority over load. Reset during CONV aborts the conversion with no done pulse, and the display returns to all "0" on the next edge.
- done is never asserted for a dropped load.

## Test plan
- Hex, NUM_DIGITS=6, value_in=0x12AB3F, mode_dec=0, blank_lz=0 -> seg_out digits 5..0 = F9,A4,88,83,B0,8E at N+2; done pulse at N+2; busy never 1.
- Decimal, value_in=999999 -> busy high for 24 cycles; at N+26 all six digits = 98, done=1.
- Decimal, value_in=1000000 -> all six digits = 3F (dash), with blank_lz=1 as well.
- Hex, value_in=0x00000A, blank_lz=1 -> digit 0 = 88, digits 1..5 = 7F. Repeat with value_in=0 -> digit 0 = C0, others = 7F.
- Decimal load of 123, then a second load at N+5 while busy -> second load ignored; display digits 2..0 = F9,A4,B0, upper digits C0; exactly one done pulse.
- Reset at N+10 of a decimal conversion -> next edge: busy=0, all digits C0, no done. Repeat with ACTIVE_LOW=0 -> all digits 3F after reset.
